// File: rtl/hellow_world_pio_pkg.sv
// Shared definitions for the hellow_world LED and switch PIO slaves on the Nios II data bus.
package hellow_world_pio_pkg;

    localparam int DEFAULT_WIDTH     = 10;
    localparam int DEFAULT_CNT_WIDTH = 24;

    typedef enum logic [1:0] {
        ADDR_DATA   = 2'd0,
        ADDR_MASK   = 2'd1,
        ADDR_PERIOD = 2'd2,
        ADDR_CLR    = 2'd3
    } pio_addr_e;

endpackage

// File: rtl/hellow_world_blink_timer.sv
// Prescaled blink timer: phase toggles every period+1 cycles; period==0 disables blinking.
module hellow_world_blink_timer
    import hellow_world_pio_pkg::*;
#(
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic                 load,
    output logic                 phase
);

    logic [CNT_WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (load) begin
            // A fresh period restarts the cycle and wins over a coincident tick.
            count <= period;
            phase <= 1'b0;
        end else if (period == '0) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == '0) begin
            count <= period;
            phase <= ~phase;
        end else begin
            count <= count - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/hellow_world_led_pio.sv
// Avalon-MM LED PIO: data register, clear-on-write port, blink mask and hardware blink timer.
module hellow_world_led_pio
    import hellow_world_pio_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]     data_reg;
    logic [WIDTH-1:0]     mask_reg;
    logic [CNT_WIDTH-1:0] period_reg;
    logic [CNT_WIDTH-1:0] period_in;
    logic                 phase;
    logic                 wr_en;
    logic                 wr_period;
    logic [31:0]          rd_mux;
    logic                 unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_period    = wr_en && (pio_addr_e'(address) == ADDR_PERIOD);
    // The timer reloads from the value being written, not the stale register.
    assign period_in    = wr_period ? writedata[CNT_WIDTH-1:0] : period_reg;
    assign unused_wdata = ^writedata;

    hellow_world_blink_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_blink_timer (
        .clk    (clk),
        .reset  (reset),
        .period (period_in),
        .load   (wr_period),
        .phase  (phase)
    );

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        if (chipselect) begin
            case (pio_addr_e'(address))
                ADDR_DATA:   rd_mux = 32'(data_reg);
                ADDR_MASK:   rd_mux = 32'(mask_reg);
                ADDR_PERIOD: rd_mux = 32'(period_reg);
                ADDR_CLR:    rd_mux = {31'b0, phase};
                default:     rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_reg   <= RESET_VALUE;
            mask_reg   <= '0;
            period_reg <= '0;
            readdata   <= '0;
            out_port   <= RESET_VALUE;
        end else begin
            readdata <= rd_mux;
            out_port <= data_reg ^ (mask_reg & {WIDTH{phase}});
            if (wr_en) begin
                case (pio_addr_e'(address))
                    ADDR_DATA:   data_reg   <= writedata[WIDTH-1:0];
                    ADDR_MASK:   mask_reg   <= writedata[WIDTH-1:0];
                    ADDR_PERIOD: period_reg <= writedata[CNT_WIDTH-1:0];
                    ADDR_CLR:    data_reg   <= data_reg & ~writedata[WIDTH-1:0];
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hellow_world_led_pio.sv
// Self-checking bench for hellow_world_led_pio: directed vector table, hand sequences, random vs model.
module tb_hellow_world_led_pio;

    localparam int              WIDTH     = 10;
    localparam int              CNT_WIDTH = 24;
    localparam logic [WIDTH-1:0] RV       = '0;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    hellow_world_led_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RV),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Reference model: phase derived from elapsed cycles since the last PERIOD write.
    logic [WIDTH-1:0] m_data;
    logic [WIDTH-1:0] m_mask;
    int unsigned      m_period;
    int unsigned      m_since;
    logic [31:0]      m_exp_rd;
    logic [WIDTH-1:0] m_exp_out;

    function automatic logic m_phase();
        if (m_period == 0) return 1'b0;
        return ((m_since / (m_period + 1)) % 2) == 1;
    endfunction

    task automatic apply(input logic r, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] wd);
        logic ph;
        reset      = r;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        ph = m_phase();
        if (r) begin
            m_exp_rd  = 0;
            m_exp_out = RV;
            m_data    = RV;
            m_mask    = '0;
            m_period  = 0;
            m_since   = 0;
        end else begin
            m_exp_rd = 0;
            if (cs) begin
                case (a)
                    2'd0: m_exp_rd = {22'b0, m_data};
                    2'd1: m_exp_rd = {22'b0, m_mask};
                    2'd2: m_exp_rd = m_period;
                    default: m_exp_rd = {31'b0, ph};
                endcase
            end
            m_exp_out = m_data ^ (ph ? m_mask : '0);
            m_since++;
            if (cs && !wn) begin
                case (a)
                    2'd0: m_data = wd[WIDTH-1:0];
                    2'd1: m_mask = wd[WIDTH-1:0];
                    2'd2: begin
                        m_period = wd & 32'h00FF_FFFF;
                        m_since  = 0;
                    end
                    default: m_data = m_data & ~wd[WIDTH-1:0];
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic             rst;
        logic             cs;
        logic             wr_n;
        logic [1:0]       addr;
        logic [31:0]      wd;
        logic [31:0]      exp_rd;
        logic [WIDTH-1:0] exp_out;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic cs, input logic wn, input logic [1:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic [WIDTH-1:0] eo);
        vec_t v;
        v.rst = r; v.cs = cs; v.wr_n = wn; v.addr = a; v.wd = wd; v.exp_rd = er; v.exp_out = eo;
        return v;
    endfunction

    vec_t vecs[29];

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        m_data = RV; m_mask = '0; m_period = 0; m_since = 0;

        vecs[0]  = mk(1, 0, 1, 0, 0,      0,      10'h000);   // reset held 3 cycles
        vecs[1]  = mk(1, 0, 1, 0, 0,      0,      10'h000);
        vecs[2]  = mk(1, 0, 1, 0, 0,      0,      10'h000);
        vecs[3]  = mk(0, 1, 1, 0, 0,      0,      10'h000);   // read DATA after reset
        vecs[4]  = mk(0, 1, 0, 0, 32'hFFFF_F2A5, 0, 10'h000); // write DATA, upper bits ignored
        vecs[5]  = mk(0, 0, 1, 0, 0,      0,      10'h2A5);   // 2nd edge after write
        vecs[6]  = mk(0, 1, 1, 0, 0,      32'h2A5, 10'h2A5);
        vecs[7]  = mk(0, 0, 1, 0, 0,      0,      10'h2A5);   // chipselect=0 read
        vecs[8]  = mk(0, 1, 0, 3, 32'h0F0, 0,     10'h2A5);   // OUTCLEAR
        vecs[9]  = mk(0, 1, 1, 0, 0,      32'h205, 10'h205);
        vecs[10] = mk(0, 1, 0, 0, 0,      32'h205, 10'h205);  // DATA=0
        vecs[11] = mk(0, 1, 0, 1, 1,      0,      10'h000);   // MASK=1
        vecs[12] = mk(0, 1, 0, 2, 3,      0,      10'h000);   // PERIOD=3
        vecs[13] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[14] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[15] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[16] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[17] = mk(0, 1, 1, 3, 0,      1,      10'h001);
        vecs[18] = mk(0, 1, 1, 3, 0,      1,      10'h001);
        vecs[19] = mk(0, 1, 1, 3, 0,      1,      10'h001);
        vecs[20] = mk(0, 1, 1, 3, 0,      1,      10'h001);
        vecs[21] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[22] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[23] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[24] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[25] = mk(0, 1, 1, 3, 0,      1,      10'h001);
        vecs[26] = mk(0, 1, 0, 2, 0,      3,      10'h001);   // PERIOD=0 while phase=1
        vecs[27] = mk(0, 1, 1, 3, 0,      0,      10'h000);
        vecs[28] = mk(0, 0, 1, 0, 0,      0,      10'h000);

        for (int i = 0; i < 29; i++) begin
            apply(vecs[i].rst, vecs[i].cs, vecs[i].wr_n, vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
        end

        // PERIOD rewrite on the exact tick edge: no toggle, next toggle 6 cycles later.
        apply(0, 1, 0, 2, 3);
        for (int i = 0; i < 3; i++) apply(0, 0, 1, 0, 0);
        apply(0, 1, 0, 2, 5);
        for (int k = 1; k <= 7; k++) begin
            apply(0, 1, 1, 3, 0);
            check($sformatf("tick_override k%0d phase", k), readdata, (k == 7) ? 32'd1 : 32'd0);
            check($sformatf("tick_override k%0d out", k), 32'(out_port), (k == 7) ? 32'd1 : 32'd0);
        end

        // Reset mid-blink with phase=1.
        apply(0, 1, 0, 0, 32'h155);
        apply(0, 0, 1, 0, 0);
        check("preblink out", 32'(out_port), 32'h154);
        apply(1, 1, 1, 3, 0);
        check("midreset readdata", readdata, 0);
        check("midreset out", 32'(out_port), 32'(RV));
        apply(0, 1, 1, 3, 0);
        check("postreset phase", readdata, 0);
        check("postreset out", 32'(out_port), 32'(RV));
        apply(0, 1, 1, 1, 0);
        check("postreset mask", readdata, 0);
        apply(0, 1, 1, 2, 0);
        check("postreset period", readdata, 0);
        apply(0, 1, 1, 0, 0);
        check("postreset data", readdata, 32'(RV));

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [1:0]  a;
            logic [31:0] wd;
            r  = ($urandom_range(0, 199) == 0);
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            if (a == 2'd2 && $urandom_range(0, 3) != 0) wd = {wd[31:24], 21'b0, wd[2:0]};
            apply(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), a, wd);
            check($sformatf("rand%0d readdata", i), readdata, m_exp_rd);
            check($sformatf("rand%0d out_port", i), 32'(out_port), 32'(m_exp_out));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
